// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Accepts a program image as a byte
//   stream over a valid/ready handshake, packs every 4 bytes big-endian
//   (first byte in [31:24]) into a 32-bit instruction word and writes the
//   words to consecutive RAM word addresses starting at 0. While a load is in
//   progress the fetch unit is held so decoding starts on a complete image.
//
// Parameters
//   ADDR_W      instruction RAM word-address width (depth = 2**ADDR_W words)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-low
//   start       in   1-cycle request to begin a load
//   word_count  in   number of words to load (ADDR_W+1 bits), sampled on start
//   byte_in     in   stream byte
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader accepts a byte this cycle
//   mem_we      out  instruction RAM write enable
//   mem_addr    out  RAM word address
//   mem_wdata   out  RAM write data
//   cpu_hold    out  hold request to the fetch unit
//   busy        out  load in progress (receiving or writing)
//   done        out  1-cycle pulse: load complete
//   err         out  1-cycle pulse: illegal start request
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Largest legal count: the full RAM depth, representable because the
    // count is one bit wider than the address.
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W:0]   r_count;       // latched number of words to load
    logic [ADDR_W:0]   r_word_addr;   // one bit wider so it never wraps to 0
    logic [1:0]        r_byte_cnt;    // byte position within the current word
    logic [23:0]       r_word;        // bytes 0..2 of the word being assembled

    logic              r_byte_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;

    logic              w_count_ok;
    logic              w_xfer;
    logic              w_last_byte;
    logic [ADDR_W:0]   w_word_addr_inc;
    logic              w_last_word;
    logic              w_err_nxt;

    assign w_count_ok      = (word_count != '0) && (word_count <= MAX_COUNT);
    // byte_ready is registered and equals "state is RECV", so the handshake
    // completes exactly when the FSM sits in RECV with valid data offered.
    assign w_xfer          = r_byte_ready & byte_valid;
    assign w_last_byte     = w_xfer && (r_byte_cnt == 2'd3);
    assign w_word_addr_inc = r_word_addr + 1'b1;
    assign w_last_word     = (w_word_addr_inc == r_count);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and illegal-start detection
    // -------------------------------------------------------------------------
    // NOTE: defaults are assigned first so no path leaves a variable unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_count_ok) begin
                        w_state_nxt = S_RECV;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_RECV: begin
                w_err_nxt = start;
                if (w_last_byte) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_err_nxt   = start;
                w_state_nxt = w_last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                w_err_nxt   = start;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs and datapath. Outputs are decoded from the next state
    // so they line up with the state they describe.
    // -------------------------------------------------------------------------
    // NOTE: only control/datapath registers are reset here; the RAM itself lives
    // outside this block and keeps its contents across a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count      <= '0;
            r_word_addr  <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_byte_ready <= (w_state_nxt == S_RECV);
            r_cpu_hold   <= (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE);
            r_mem_we     <= (w_state_nxt == S_WRITE);
            r_done       <= (w_state_nxt == S_DONE);
            r_err        <= w_err_nxt;

            if ((r_state == S_IDLE) && start && w_count_ok) begin
                r_count     <= word_count;
                r_word_addr <= '0;
                r_byte_cnt  <= '0;
            end

            if (w_xfer) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                unique case (r_byte_cnt)
                    2'd0: r_word[23:16] <= byte_in;
                    2'd1: r_word[15:8]  <= byte_in;
                    2'd2: r_word[7:0]   <= byte_in;
                    default: begin
                        // Last byte bypasses the assembly register straight
                        // into the write data so WRITE follows immediately.
                        r_mem_wdata <= {r_word, byte_in};
                        r_mem_addr  <= r_word_addr[ADDR_W-1:0];
                    end
                endcase
            end

            if (r_state == S_WRITE) begin
                r_word_addr <= w_word_addr_inc;
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign busy       = r_cpu_hold;
    assign done       = r_done;
    assign err        = r_err;

endmodule
